// File: rtl/alu_seq.sv
// Registered ALU with start/busy/done handshake: single-cycle logic/arithmetic,
// multi-cycle shift-add multiply and (with ALU_SEQ_DIV_EN) restoring divide.
//
// state | meaning
// IDLE  | accepting start; single-cycle ops complete here
// MUL   | shift-add multiply, one partial product per clock
// DIV   | restoring divide, one quotient bit per clock
module alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       operate,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             done,
    output logic             busy,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             neg,
    output logic             err
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_c;
    logic             r_v;
    logic             r_err;
    logic             go_mul;
    logic [WIDTH-1:0] st_hi;
    logic [WIDTH-1:0] st_lo;
`ifdef ALU_SEQ_DIV_EN
    logic             go_div;
    logic [WIDTH:0]   div_trial;
`endif

    assign sum     = {1'b0, in0} + {1'b0, in1};
    assign diff    = {1'b0, in0} - {1'b0, in1};
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
`ifdef ALU_SEQ_DIV_EN
    // Borrow out of the (WIDTH+1)-bit trial subtract means "restore".
    assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opb};
`endif

    always_comb begin
        r_lo   = '0;
        r_hi   = '0;
        r_c    = 1'b0;
        r_v    = 1'b0;
        r_err  = 1'b0;
        go_mul = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        go_div = 1'b0;
`endif
        case (operate)
            4'h0: begin
                r_lo = sum[WIDTH-1:0];
                r_c  = sum[WIDTH];
                r_v  = (in0[WIDTH-1] == in1[WIDTH-1]) && (sum[WIDTH-1] != in0[WIDTH-1]);
            end
            4'h1: begin
                r_lo = diff[WIDTH-1:0];
                r_c  = diff[WIDTH];
                r_v  = (in0[WIDTH-1] != in1[WIDTH-1]) && (diff[WIDTH-1] != in0[WIDTH-1]);
            end
            4'h2: r_lo = in0 & in1;
            4'h3: r_lo = in0 | in1;
            4'h4: r_lo = in0 ^ in1;
            4'h5: r_lo = ~in0;
            4'h6: r_lo = in0 << in1[SHW-1:0];
            4'h7: r_lo = in0 >> in1[SHW-1:0];
            4'h8: r_lo = $signed(in0) >>> in1[SHW-1:0];
            4'h9: r_lo = {{(WIDTH-1){1'b0}}, ($signed(in0) < $signed(in1))};
            4'hA: go_mul = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            4'hB: begin
                if (in1 == '0) begin
                    r_lo  = '1;
                    r_hi  = in0;
                    r_err = 1'b1;
                end else begin
                    go_div = 1'b1;
                end
            end
`endif
            default: r_err = 1'b1;
        endcase
    end

    always_comb begin
        st_hi = mul_sum[WIDTH:1];
        st_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        if (state == DIV) begin
            if (!div_trial[WIDTH]) begin
                st_hi = div_trial[WIDTH-1:0];
                st_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                st_hi = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
                st_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            opb    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            out    <= '0;
            out_hi <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            neg    <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (go_mul) begin
                            opb    <= in1;
                            acc_lo <= in0;
                            acc_hi <= '0;
                            cnt    <= CW'(WIDTH);
                            busy   <= 1'b1;
                            state  <= MUL;
                        end
`ifdef ALU_SEQ_DIV_EN
                        else if (go_div) begin
                            opb    <= in1;
                            acc_lo <= in0;
                            acc_hi <= '0;
                            cnt    <= CW'(WIDTH);
                            busy   <= 1'b1;
                            state  <= DIV;
                        end
`endif
                        else begin
                            out    <= r_lo;
                            out_hi <= r_hi;
                            zero   <= (r_lo == '0);
                            neg    <= r_lo[WIDTH-1];
                            carry  <= r_c;
                            ovf    <= r_v;
                            err    <= r_err;
                            done   <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_hi <= st_hi;
                    acc_lo <= st_lo;
                    cnt    <= cnt - CW'(1);
                    // Last iteration: publish the post-step values directly.
                    if (cnt == CW'(1)) begin
                        out    <= st_lo;
                        out_hi <= st_hi;
                        zero   <= (st_lo == '0);
                        neg    <= st_lo[WIDTH-1];
                        carry  <= 1'b0;
                        ovf    <= 1'b0;
                        err    <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16): directed cases plus random ops
// against an arithmetic reference model; follows ALU_SEQ_DIV_EN like the RTL.
module tb_alu_seq;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   operate;
    logic [W-1:0] in0, in1;
    logic [W-1:0] out, out_hi;
    logic         done, busy, zero, carry, ovf, neg, err;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .operate(operate),
        .in0(in0), .in1(in1), .out(out), .out_hi(out_hi),
        .done(done), .busy(busy), .zero(zero), .carry(carry),
        .ovf(ovf), .neg(neg), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] o;
        logic [W-1:0] h;
        logic z, c, v, n, e;
        int   cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_multi(input logic [3:0] op, input logic [W-1:0] b);
`ifdef ALU_SEQ_DIV_EN
        return (op == 4'hA) || (op == 4'hB && b != 0);
`else
        return (op == 4'hA);
`endif
    endfunction

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   m;
        int     sa, sb, sr, r;
        longint p;
        sa = $signed(a);
        sb = $signed(b);
        m.o = '0; m.h = '0; m.c = 0; m.v = 0; m.e = 0; m.cyc = 0;
        case (op)
            4'h0: begin
                r = a + b;
                m.o = r[W-1:0];
                m.c = (r > 65535);
                sr = sa + sb;
                m.v = (sr > 32767) || (sr < -32768);
            end
            4'h1: begin
                r = a - b;
                m.o = r[W-1:0];
                m.c = (a < b);
                sr = sa - sb;
                m.v = (sr > 32767) || (sr < -32768);
            end
            4'h2: m.o = a & b;
            4'h3: m.o = a | b;
            4'h4: m.o = a ^ b;
            4'h5: m.o = ~a;
            4'h6: m.o = a << b[3:0];
            4'h7: m.o = a >> b[3:0];
            4'h8: begin
                r = sa >>> b[3:0];
                m.o = r[W-1:0];
            end
            4'h9: m.o = (sa < sb) ? 1 : 0;
            4'hA: begin
                p = longint'(a) * longint'(b);
                m.o = p[15:0];
                m.h = p[31:16];
            end
`ifdef ALU_SEQ_DIV_EN
            4'hB: begin
                if (b == 0) begin
                    m.o = 16'hFFFF;
                    m.h = a;
                    m.e = 1;
                end else begin
                    m.o = a / b;
                    m.h = a % b;
                end
            end
`endif
            default: m.e = 1;
        endcase
        m.z = (m.o == 0);
        m.n = m.o[W-1];
        return m;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("done_expected", {31'd0, q.size() != 0}, 32'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("out",    out,    e.o);
                chk("out_hi", out_hi, e.h);
                chk("zero",   zero,   e.z);
                chk("carry",  carry,  e.c);
                chk("ovf",    ovf,    e.v);
                chk("neg",    neg,    e.n);
                chk("err",    err,    e.e);
                chk("busy_at_done", busy, 0);
                chk("latency_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_idle: timeout with %0d pending, required 0", q.size());
            q.delete();
        end
    endtask

    // Drives one request at posedge+1; multi-cycle ops are waited out here.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit poke);
        exp_t e;
        bit   multi;
        multi = is_multi(op, b);
        start = 1; operate = op; in0 = a; in1 = b;
        e = model(op, a, b);
        e.cyc = cyc + (multi ? W + 1 : 1);
        q.push_back(e);
        @(posedge clk); #1;
        if (multi) begin
            start = 0;
            if (poke) begin
                repeat (4) begin @(posedge clk); #1; end
                start = 1; operate = 4'h0; in0 = 16'h0001; in1 = 16'h0001;
                @(posedge clk); #1;
                start = 0;
            end
            wait_idle();
        end
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {out, out_hi, done, busy, zero, carry, ovf, neg, err}, 0);
    endtask

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a, b;
        rst = 1; start = 0; operate = 0; in0 = 0; in1 = 0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_outputs");
        @(negedge clk) rst = 0;
        @(posedge clk); #1;

        // Back-to-back single-cycle ops 0..9 with start held high.
        for (int i = 0; i < 10; i++) issue(4'(i), 16'h000F, 16'h0002, 0);
        start = 0;
        wait_idle();

        issue(4'h1, 16'h0002, 16'h000F, 0);
        issue(4'h0, 16'h7FFF, 16'h0001, 0);
        start = 0;
        wait_idle();

        issue(4'hA, 16'h000F, 16'h0002, 0);
        issue(4'hA, 16'hFFFF, 16'hFFFF, 1);
        issue(4'hB, 16'h000F, 16'h0002, 0);
        issue(4'hB, 16'h000F, 16'h0000, 0);
        issue(4'hE, 16'h1234, 16'h5678, 0);
        issue(4'h0, 16'h0001, 16'h0001, 0);
        start = 0;
        wait_idle();

        // Random traffic, occasional idle gaps and zero/corner operands.
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: a = 16'h8000;
                1: a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: b = 16'h0000;
                1: b = 16'($urandom_range(1, 17));
                default: b = 16'($urandom);
            endcase
            issue(op, a, b, 0);
            if ($urandom_range(0, 3) == 0) begin
                start = 0;
                @(posedge clk); #1;
            end
        end
        start = 0;
        wait_idle();

        // Asynchronous reset during the 8th MUL cycle aborts without done.
        start = 1; operate = 4'hA; in0 = 16'h1234; in1 = 16'h5678;
        @(posedge clk); #1;
        start = 0;
        repeat (7) @(posedge clk);
        #2 rst = 1;
        #1 check_all_zero("async_reset_mid_mul");
        q.delete();
        @(negedge clk) rst = 0;
        repeat (20) begin @(posedge clk); #1; end
        issue(4'h0, 16'h0003, 16'h0004, 0);
        start = 0;
        wait_idle();

        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

endmodule
